// File: rtl/sort_seq.sv
// Sequential buffered sorter: captures DEPTH words, bubble-sorts them one compare per clock, streams them out.
// Build option: define SORT_DESCEND_EN for descending output order (default ascending).
module sort_seq #(
    parameter int n     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SORT   = 2'd1;
    localparam logic [1:0] ST_UNLOAD = 2'd2;

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_CMP = PW'(DEPTH - 2);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [1:0]    state_q, state_d;
    logic [n-1:0]  mem_q [DEPTH];
    logic [n-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] cmp_q, cmp_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [n-1:0]  out_data_q, out_data_d;

    logic [n-1:0]  cmp_a_s;
    logic [n-1:0]  cmp_b_s;
    logic          swap_s;

    assign cmp_a_s = mem_q[cmp_q];
    assign cmp_b_s = mem_q[cmp_q + PTR_ONE];
`ifdef SORT_DESCEND_EN
    assign swap_s  = (cmp_a_s < cmp_b_s);
`else
    assign swap_s  = (cmp_a_s > cmp_b_s);
`endif

    // Next-state logic for the load / sort / unload sequence and the word storage.
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cmp_d    = cmp_q;
        pass_d   = pass_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_ptr_q] = in_data;
                    if (wr_ptr_q == LAST_IDX) begin
                        wr_ptr_d = {PW{1'b0}};
                        state_d  = ST_SORT;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
            end
            ST_SORT: begin
                // Fixed-length bubble sort: DEPTH-1 passes, no early exit, ties never swapped.
                if (swap_s) begin
                    mem_d[cmp_q]           = cmp_b_s;
                    mem_d[cmp_q + PTR_ONE] = cmp_a_s;
                end else begin
                    mem_d = mem_q;
                end
                if (cmp_q == LAST_CMP) begin
                    cmp_d = {PW{1'b0}};
                    if (pass_q == LAST_CMP) begin
                        pass_d   = {PW{1'b0}};
                        rd_ptr_d = {PW{1'b0}};
                        state_d  = ST_UNLOAD;
                    end else begin
                        pass_d = pass_q + PTR_ONE;
                    end
                end else begin
                    cmp_d = cmp_q + PTR_ONE;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST_IDX) begin
                        rd_ptr_d = {PW{1'b0}};
                        state_d  = ST_LOAD;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Output registers follow the next state so they are valid from the first cycle of each state.
    always_comb begin
        in_ready_d  = (state_d == ST_LOAD);
        busy_d      = (state_d == ST_SORT);
        out_valid_d = (state_d == ST_UNLOAD);
        out_data_d  = (state_d == ST_UNLOAD) ? mem_d[rd_ptr_d] : {n{1'b0}};
    end

    // State, storage and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            cmp_q       <= {PW{1'b0}};
            pass_q      <= {PW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= {n{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {n{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmp_q       <= cmp_d;
            pass_q      <= pass_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            mem_q       <= mem_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    // Pulse coincides with the handshake that accepts the last word of the block.
    assign done      = out_valid_q & out_ready & (rd_ptr_q == LAST_IDX);

endmodule

// File: tb/tb_sort_seq.sv
// Scoreboard bench for sort_seq: a stable-insertion reference model fills the expected queue, a monitor checks outputs.
module tb_sort_seq;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int SORT_CYC = (DEPTH - 1) * (DEPTH - 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         done;

    sort_seq #(.n(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] blk[$];
    int out_idx = 0;
    int blocks_done = 0;
    int acc_edge = 0;
    int busy_cnt = 0;
    bit sort_pending = 1'b0;
    bit hold_prev = 1'b0;
    bit inready_next = 1'b0;
    logic [N-1:0] hold_data = '0;
    int ready_mode = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: stable insertion of each captured word into an ordered list.
    function automatic void push_expected();
        logic [N-1:0] s[$];
        foreach (blk[k]) begin
            int sz;
            int pos;
            sz  = s.size();
            pos = sz;
            for (int j = 0; j < sz; j++) begin
`ifdef SORT_DESCEND_EN
                if (pos == sz && s[j] < blk[k]) pos = j;
`else
                if (pos == sz && s[j] > blk[k]) pos = j;
`endif
            end
            s.insert(pos, blk[k]);
        end
        foreach (s[k]) exp_q.push_back(s[k]);
    endfunction

    // Monitor: samples on the falling edge, captures inputs into the model and checks outputs.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (inready_next) begin
                check("in_ready_after_done", in_ready, 1);
                inready_next = 1'b0;
            end
            if (sort_pending) begin
                if (out_valid) begin
                    check("first_valid_latency", cyc + 1 - acc_edge, SORT_CYC + 1);
                    check("busy_cycles", busy_cnt, SORT_CYC);
                    check("busy_in_unload", busy, 0);
                    sort_pending = 1'b0;
                end else if (busy) begin
                    busy_cnt++;
                end
            end
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_data);
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                out_idx++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected no output", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                check("done_last", done, (out_idx == DEPTH) ? 1 : 0);
                if (out_idx == DEPTH) begin
                    out_idx = 0;
                    blocks_done++;
                    inready_next = 1'b1;
                end
            end else begin
                check("done_idle", done, 0);
            end
            if (in_valid && in_ready) begin
                blk.push_back(in_data);
                if (blk.size() == DEPTH) begin
                    push_expected();
                    blk.delete();
                    acc_edge = cyc + 1;
                    sort_pending = 1'b1;
                    busy_cnt = 0;
                end
            end
        end
    end

    // Consumer: out_ready pattern chosen by ready_mode (always, toggling, random).
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic load_block(input logic [N-1:0] w [DEPTH], input int max_gap, input bit hold);
        for (int i = 0; i < DEPTH; i++) begin
            int gap;
            bit acc;
            int budget;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            in_data  = w[i];
            in_valid = 1'b1;
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 100) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL load_timeout: got no accept, expected accept within 100 cycles");
            end
        end
        in_data  = 8'hAA;
        in_valid = hold;
    endtask

    task automatic wait_done(input int target);
        int budget;
        budget = 0;
        while (blocks_done < target && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        if (blocks_done < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d blocks, expected %0d", blocks_done, target);
        end
    endtask

    task automatic run_block(input logic [N-1:0] w [DEPTH], input int max_gap, input int mode, input bit hold);
        int target;
        target = blocks_done + 1;
        ready_mode = mode;
        load_block(w, max_gap, hold);
        wait_done(target);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [N-1:0] w [DEPTH];

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        w = '{8'h07, 8'h02, 8'h09, 8'h01};
        run_block(w, 0, 0, 1'b0);
        w = '{8'h05, 8'h05, 8'h03, 8'h05};
        run_block(w, 1, 0, 1'b0);
        w = '{8'hFF, 8'h00, 8'h80, 8'h7F};
        run_block(w, 0, 1, 1'b0);
        w = '{8'h10, 8'h30, 8'h20, 8'h00};
        run_block(w, 0, 2, 1'b1);

        // Reset in the fourth SORT cycle must discard the block.
        ready_mode = 0;
        w = '{8'h09, 8'h03, 8'h07, 8'h01};
        load_block(w, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midsort_rst_in_ready", in_ready, 1);
        check("midsort_rst_out_valid", out_valid, 0);
        check("midsort_rst_busy", busy, 0);
        exp_q.delete();
        blk.delete();
        sort_pending = 1'b0;
        hold_prev = 1'b0;
        inready_next = 1'b0;
        out_idx = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("no_output_after_reset", out_valid, 0);
        w = '{8'h04, 8'h03, 8'h02, 8'h01};
        run_block(w, 0, 0, 1'b0);

        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w[i] = (b % 2 == 0) ? N'($urandom_range(0, 3)) : N'($urandom);
            end
            run_block(w, 2, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_seq.md
Name: sort_seq

Overview:
- Sequential buffered sorter for the sort datapath. Captures a block of DEPTH unsigned n-bit words over a valid/ready input stream.
- Sorts the block in place using a single unsigned magnitude compare per clock: eq/lt/gt semantics, swap only on strict gt.
- Streams the sorted block out over a valid/ready output stream.
- Sits between a word producer and the downstream consumer; one block in flight at a time.

Parameters:
- n, 8, word width in bits (unsigned).
- DEPTH, 4, words per block; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_data  input  n  word to load.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sorter can accept a word this cycle.
- out_data  output  n  sorted word presented.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  high in SORT state.
- done  output  1  one-cycle pulse on the cycle the last sorted word is accepted.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - rst high forces state LOAD and zeroes load/pass/compare/read counters and all storage words.
  - Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, done=0.
  - Reset asserted mid-SORT or mid-UNLOAD discards the block; no partial output follows.
- Transfers occur only on rising clk when valid and ready are both high.
- State LOAD:
  - in_ready=1; each accepted word is written to mem[wr_ptr] and wr_ptr increments.
  - The cycle accepting word DEPTH-1 moves to SORT; wr_ptr returns to 0.
  - in_valid=0 stalls with no state change.
- State SORT:
  - in_ready=0, out_valid=0, busy=1.
  - Each cycle compares mem[i] and mem[i+1], i = 0..DEPTH-2.
  - Swap if mem[i] > mem[i+1]. Equal words are not swapped, so the sort is stable.
  - A pass is DEPTH-1 compares. Exactly DEPTH-1 passes are run, with no early exit.
  - SORT length is fixed at (DEPTH-1)*(DEPTH-1) cycles: 9 for DEPTH=4.
  - After the final compare, go to UNLOAD; rd_ptr=0.
  - in_valid during SORT is ignored; the word is not captured.
- State UNLOAD:
  - out_valid=1, out_data=mem[rd_ptr]. Registered: valid from the first UNLOAD cycle.
  - Each accepted word increments rd_ptr.
  - out_ready=0 holds out_data and out_valid stable.
  - Acceptance of word DEPTH-1: done=1 for that cycle, state returns to LOAD, in_ready=1 from the next cycle.
  - No input is accepted during UNLOAD.
- Comparison is pure unsigned over n bits; no sign extension.
- Counter widths are sized by clog2(DEPTH); pointers never wrap within a state.
- Latency from last input accept to first out_valid: (DEPTH-1)^2 + 1 cycles.
- Throughput: one block per DEPTH + (DEPTH-1)^2 + DEPTH cycles minimum.

Optional Feature:
- SORT_DESCEND_EN defined: the swap condition becomes mem[i] < mem[i+1], giving descending output. Ties are still not swapped.
- Undefined: ascending output, as above. Latency and handshake are identical in both builds.

Test Plan:
- Reset, then load 8'h07, 8'h02, 8'h09, 8'h01 with out_ready=1 -> out_data sequence 01, 02, 07, 09.
  - out_valid first high exactly 10 cycles after the last in accept.
  - done pulses with 09; in_ready=1 on the next cycle.
- Load 05, 05, 03, 05 -> output 03, 05, 05, 05. With tagged n=16 words, equal keys keep their input order (stability).
- Load FF, 00, 80, 7F with out_ready toggling 1/0 each cycle -> output 00, 7F, 80, FF; each word held stable while out_ready=0.
- Hold in_valid=1 through SORT and UNLOAD -> no extra words captured; the next block starts cleanly at LOAD.
- Assert rst at SORT cycle 4 of a block -> immediately in_ready=1, out_valid=0, busy=0. A fresh block 04, 03, 02, 01 then sorts to 01, 02, 03, 04.
- Build with SORT_DESCEND_EN, load 07, 02, 09, 01 -> output 09, 07, 02, 01 with identical timing.
